// File: rtl/tree_level_stage_if.sv
// Upstream sample port, downstream result port and node-table config port of one tree level.
interface tree_level_stage_if #(parameter int STAGE = 1);
  logic             in_valid;
  logic             in_ready;
  logic [255:0]     sample_i;
  logic [STAGE-1:0] node_idx_i;
  logic             out_valid;
  logic             out_ready;
  logic [255:0]     sample_o;
  logic [STAGE:0]   node_idx_o;
  logic             cfg_we;
  logic [STAGE-1:0] cfg_addr;
  logic [12:0]      cfg_data;
  logic [15:0]      sample_cnt;

  modport slave (
    input  in_valid, sample_i, node_idx_i, out_ready, cfg_we, cfg_addr, cfg_data,
    output in_ready, out_valid, sample_o, node_idx_o, sample_cnt
  );

  modport master (
    output in_valid, sample_i, node_idx_i, out_ready, cfg_we, cfg_addr, cfg_data,
    input  in_ready, out_valid, sample_o, node_idx_o, sample_cnt
  );
endinterface

// File: rtl/tree_level_stage.sv
// One decision-tree depth level: node lookup (S1), feature/threshold compare (S2),
// appends the branch bit to the node index.
module tree_level_stage #(
  parameter int STAGE  = 1,
  parameter int FEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tree_level_stage_if.slave bus
);
  localparam int NODES = 1 << STAGE;
  localparam int NFEAT = 256 / FEAT_W;

  typedef struct packed {
    logic [4:0]        feat_sel;
    logic [FEAT_W-1:0] thr;
  } node_t;

  node_t tab [NODES];

  logic                        s1_valid, s2_valid;
  logic [FEAT_W-1:0]           s1_feat, s1_thr;
  logic [255:0]                s1_sample, s2_sample;
  logic [STAGE-1:0]            s1_idx;
  logic [STAGE:0]              s2_idx;
  logic [15:0]                 cnt;
  logic                        s1_en, s2_en;
  node_t                       entry;
  logic [NFEAT-1:0][FEAT_W-1:0] feats;

  assign s2_en = !s2_valid || bus.out_ready;
  assign s1_en = !s1_valid || s2_en;

  // Lookup reads the pre-write entry, so a same-edge cfg write only affects later captures.
  assign entry = tab[bus.node_idx_i];
  assign feats = bus.sample_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) tab[i] <= '0;
    end else if (bus.cfg_we) begin
      tab[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_feat   <= '0;
      s1_thr    <= '0;
      s1_sample <= '0;
      s1_idx    <= '0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_feat   <= feats[entry.feat_sel];
        s1_thr    <= entry.thr;
        s1_sample <= bus.sample_i;
        s1_idx    <= bus.node_idx_i;
      end
    end
  end

  // Equality takes the left branch (decision 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_sample <= '0;
      s2_idx    <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sample <= s1_sample;
        s2_idx    <= {s1_idx, s1_feat > s1_thr};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (s2_valid && bus.out_ready) cnt <= cnt + 16'd1;
  end

  assign bus.in_ready   = s1_en;
  assign bus.out_valid  = s2_valid;
  assign bus.sample_o   = s2_sample;
  assign bus.node_idx_o = s2_idx;
  assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_tree_level_stage.sv
// Directed bench for tree_level_stage (STAGE=2) with a queue-based reference model.
module tb_tree_level_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tree_level_stage_if #(.STAGE(2)) bus();
  tree_level_stage #(.STAGE(2), .FEAT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [255:0] s;
    logic [2:0]   idx;
  } exp_t;

  exp_t        q[$];
  logic [12:0] m_tab [4];
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a transaction queue; each accepted sample is resolved against the
  // table contents that were visible before that edge's config write.
  always @(negedge clk) begin
    logic [12:0] e;
    int          sel;
    logic [7:0]  f;
    exp_t        x;
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_tab[i] = '0;
    end else begin
      chk("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
      if (q.size() == 0) chk("out_valid_empty", bus.out_valid, 1'b0);
      if (q.size() == 2) chk("out_valid_full", bus.out_valid, 1'b1);
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out actual=out_valid expected=no_output");
        end else begin
          chk("node_idx_o", bus.node_idx_o, q[0].idx);
          chk("sample_o", bus.sample_o, q[0].s);
        end
      end
      chk("sample_cnt", bus.sample_cnt, m_cnt[15:0]);
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (bus.in_valid && bus.in_ready) begin
        e   = m_tab[bus.node_idx_i];
        sel = int'(e[12:8]);
        f   = bus.sample_i[8*sel +: 8];
        x.s = bus.sample_i;
        x.idx = {bus.node_idx_i, (f > e[7:0])};
        q.push_back(x);
      end
      if (bus.cfg_we) m_tab[bus.cfg_addr] = bus.cfg_data;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [12:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    step();
    bus.cfg_we = 1'b0;
  endtask

  task automatic send(input logic [255:0] s, input logic [1:0] idx);
    bit done = 0;
    bus.in_valid = 1'b1; bus.sample_i = s; bus.node_idx_i = idx;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept");
    end
  endtask

  task automatic expect_out(input string name, input logic [2:0] idx, input logic [255:0] s);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1;
        chk(name, bus.node_idx_o, idx);
        chk({name, "_data"}, bus.sample_o, s);
      end
    end
    step();
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_output expected=%0h", name, idx);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) step();
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d expected=0", q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    checks++; errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [255:0] base, s, a, b;
    base = 256'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_1122_3344_5566_7788_99aa_bbcc_ddee_ff00;
    bus.in_valid = 0; bus.sample_i = '0; bus.node_idx_i = '0; bus.out_ready = 1'b1;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_sample_o", bus.sample_o, 256'd0);
    chk("rst_node_idx_o", bus.node_idx_o, 3'd0);
    chk("rst_cnt", bus.sample_cnt, 16'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    step();

    // basic decision and threshold boundary on feature 3
    cfg(2'd2, {5'd3, 8'h40});
    s = base; s[31:24] = 8'h41; send(s, 2'd2); expect_out("basic_gt", 3'b101, s);
    s = base; s[31:24] = 8'h40; send(s, 2'd2); expect_out("bound_eq", 3'b100, s);
    s = base; s[31:24] = 8'h00; send(s, 2'd2); expect_out("bound_zero", 3'b100, s);
    s = base; s[31:24] = 8'hff; send(s, 2'd2); expect_out("bound_max", 3'b101, s);
    drain();

    // streaming with out_ready low for cycles 3..6; zeroed table compares byte0 > 0
    do_reset();
    fork
      for (int i = 0; i < 8; i++) begin
        s = {{31{8'(8'ha0 + i)}}, 8'(i * 32)};
        send(s, 2'(i));
      end
      begin
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.out_ready = 1'b0;
        repeat (4) step();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    chk("stream_cnt", bus.sample_cnt, 16'd8);
    step();

    // config write colliding with capture of the same node
    cfg(2'd1, {5'd0, 8'h10});
    s = base; s[7:0] = 8'h80;
    bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_data = {5'd0, 8'hff};
    send(s, 2'd1);
    bus.cfg_we = 1'b0;
    expect_out("coll_old", 3'b011, s);
    send(s, 2'd1);
    expect_out("coll_new", 3'b010, s);
    drain();

    // reset with the pipe full
    bus.out_ready = 1'b0;
    a = base; b = ~base;
    send(a, 2'd0);
    send(b, 2'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_cnt", bus.sample_cnt, 16'd0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    s = base; s[7:0] = 8'h01;
    send(s, 2'd1);
    expect_out("zero_table", 3'b011, s);

    // counter wrap: 65535 more handshakes bring the total since reset to 65536
    for (int n = 0; n < 65535; n++) send(256'(n), 2'd0);
    drain();
    @(negedge clk);
    chk("cnt_wrap", bus.sample_cnt, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
